// File: rtl/led_fader_pkg.sv
// -----------------------------------------------------------------------------
// led_fader_pkg
//   Shared defaults for the LED fader block. The defaults are the production
//   configuration: 8 channels, 8-bit PWM, one fade step every 1024 clocks, and
//   active-high LED drive. Both the top and the per-channel sub-module take
//   their parameter defaults from here, so the two files cannot drift apart.
// -----------------------------------------------------------------------------
package led_fader_pkg;

  localparam int DEF_LED_WIDTH  = 8;
  localparam int DEF_PWM_WIDTH  = 8;
  localparam int DEF_STEP_DIV   = 1024;
  localparam int DEF_ACTIVE_LOW = 0;

  // Maps the integer polarity parameter onto the single XOR bit applied at
  // the output register.
  function automatic logic out_invert(input int active_low);
    logic inv_s;
    if (active_low != 0) begin
      inv_s = 1'b1;
    end else begin
      inv_s = 1'b0;
    end
    return inv_s;
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// -----------------------------------------------------------------------------
// led_fade_channel
//   One LED channel of the fader. It holds the channel's duty register, steps
//   the duty by one toward the requested level on each fade tick (saturating at
//   0 and DUTY_MAX), compares the duty against the shared PWM counter, and
//   registers the resulting drive bit. In bypass mode the duty register tracks
//   the request directly (0 or DUTY_MAX), so switching back to fade mode starts
//   from the level the LED already shows.
//
// Ports
//   clk        in   1          clock
//   rst        in   1          synchronous reset, active-high
//   en         in   1          1 = fade/PWM mode, 0 = bypass
//   tick       in   1          one-cycle fade step strobe
//   led_q      in   1          registered on/off request for this channel
//   pwm_cnt    in   PWM_WIDTH  shared free-running PWM counter
//   led_out    out  1          registered LED drive (polarity applied)
//   at_target  out  1          duty currently equals the requested level
// -----------------------------------------------------------------------------
module led_fade_channel
  import led_fader_pkg::*;
#(
  parameter int PWM_WIDTH  = DEF_PWM_WIDTH,
  parameter int ACTIVE_LOW = DEF_ACTIVE_LOW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 tick,
  input  logic                 led_q,
  input  logic [PWM_WIDTH-1:0] pwm_cnt,
  output logic                 led_out,
  output logic                 at_target
);

  localparam logic [PWM_WIDTH-1:0] DUTY_MAX  = {PWM_WIDTH{1'b1}};
  localparam logic [PWM_WIDTH-1:0] DUTY_ZERO = {PWM_WIDTH{1'b0}};
  localparam logic [PWM_WIDTH-1:0] DUTY_ONE  = {{(PWM_WIDTH-1){1'b0}}, 1'b1};
  localparam logic                 OUT_INV   = out_invert(ACTIVE_LOW);

  logic [PWM_WIDTH-1:0] duty_r;
  logic [PWM_WIDTH-1:0] duty_nxt_s;
  logic [PWM_WIDTH-1:0] target_s;
  logic                 on_s;
  logic                 drive_s;
  logic                 led_out_r;

  // Requested level, PWM compare and the pre-polarity drive bit.
  always_comb begin
    target_s = DUTY_ZERO;
    on_s     = 1'b0;
    drive_s  = 1'b0;
    if (led_q) begin
      target_s = DUTY_MAX;
    end else begin
      target_s = DUTY_ZERO;
    end
    // Full duty is forced on so the LED never blinks off once per PWM period.
    on_s = (duty_r == DUTY_MAX) | (pwm_cnt < duty_r);
    if (en) begin
      drive_s = on_s;
    end else begin
      drive_s = led_q;
    end
  end

  // Next duty: bypass snaps to the request, fade steps once per tick.
  always_comb begin
    duty_nxt_s = duty_r;
    if (!en) begin
      duty_nxt_s = target_s;
    end else if (tick && led_q && (duty_r != DUTY_MAX)) begin
      duty_nxt_s = duty_r + DUTY_ONE;
    end else if (tick && !led_q && (duty_r != DUTY_ZERO)) begin
      duty_nxt_s = duty_r - DUTY_ONE;
    end else begin
      duty_nxt_s = duty_r;
    end
  end

  // Duty register and registered LED drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_r    <= DUTY_ZERO;
      led_out_r <= OUT_INV;
    end else begin
      duty_r    <= duty_nxt_s;
      led_out_r <= drive_s ^ OUT_INV;
    end
  end

  assign led_out   = led_out_r;
  assign at_target = (duty_r == target_s);

endmodule

// File: rtl/led_fader.sv
// -----------------------------------------------------------------------------
// led_fader
//   PWM fader between the blinky pattern source and the LED output registers.
//   Each LED's brightness ramps one duty step per fade tick toward fully on or
//   fully off instead of switching hard. With en=0 the fader is bypassed and
//   the registered pattern goes straight to the outputs.
//
// Ports
//   clk        in   1          clock
//   rst        in   1          synchronous reset, active-high
//   en         in   1          1 = fade/PWM mode, 0 = bypass
//   led_in     in   LED_WIDTH  requested on/off pattern (clk domain)
//   led_out    out  LED_WIDTH  PWM LED drive, registered
//   fade_done  out  1          every channel's duty equals its target, registered
// -----------------------------------------------------------------------------
module led_fader
  import led_fader_pkg::*;
#(
  parameter int LED_WIDTH  = DEF_LED_WIDTH,
  parameter int PWM_WIDTH  = DEF_PWM_WIDTH,
  parameter int STEP_DIV   = DEF_STEP_DIV,
  parameter int ACTIVE_LOW = DEF_ACTIVE_LOW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [LED_WIDTH-1:0] led_in,
  output logic [LED_WIDTH-1:0] led_out,
  output logic                 fade_done
);

  localparam int                   PRESC_W    = $clog2(STEP_DIV);
  localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(STEP_DIV - 1);
  localparam logic [PRESC_W-1:0]   PRESC_ONE  = {{(PRESC_W-1){1'b0}}, 1'b1};
  localparam logic [PWM_WIDTH-1:0] PWM_ONE    = {{(PWM_WIDTH-1){1'b0}}, 1'b1};

  logic [LED_WIDTH-1:0] led_in_q_r;
  logic [PWM_WIDTH-1:0] pwm_cnt_r;
  logic [PRESC_W-1:0]   presc_r;
  logic                 tick_s;
  logic [LED_WIDTH-1:0] at_target_s;
  logic                 fade_done_r;

  assign tick_s = (presc_r == PRESC_LAST);

  // Input register, PWM counter, fade prescaler and the completion flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_in_q_r  <= {LED_WIDTH{1'b0}};
      pwm_cnt_r   <= {PWM_WIDTH{1'b0}};
      presc_r     <= {PRESC_W{1'b0}};
      fade_done_r <= 1'b1;
    end else begin
      led_in_q_r  <= led_in;
      pwm_cnt_r   <= pwm_cnt_r + PWM_ONE;
      // Explicit wrap so a non-power-of-two divider still gives one tick
      // every STEP_DIV cycles; the prescaler ignores en on purpose.
      if (tick_s) begin
        presc_r <= {PRESC_W{1'b0}};
      end else begin
        presc_r <= presc_r + PRESC_ONE;
      end
      fade_done_r <= &at_target_s;
    end
  end

  for (genvar i = 0; i < LED_WIDTH; i++) begin : g_ch
    led_fade_channel #(
      .PWM_WIDTH  (PWM_WIDTH),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .tick      (tick_s),
      .led_q     (led_in_q_r[i]),
      .pwm_cnt   (pwm_cnt_r),
      .led_out   (led_out[i]),
      .at_target (at_target_s[i])
    );
  end

  assign fade_done = fade_done_r;

endmodule

// File: tb/tb_led_fader.sv
// -----------------------------------------------------------------------------
// tb_led_fader
//   Bench for led_fader with 2 channels, 4-bit PWM (DUTY_MAX=15), STEP_DIV=4.
//   A cycle model predicts led_out/fade_done for each clock; the prediction is
//   queued when the inputs are driven and compared after the edge.
// -----------------------------------------------------------------------------
module tb_led_fader;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] led_in;
  logic [1:0] led_out;
  logic       fade_done;

  led_fader #(
    .LED_WIDTH  (2),
    .PWM_WIDTH  (4),
    .STEP_DIV   (4),
    .ACTIVE_LOW (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .led_in    (led_in),
    .led_out   (led_out),
    .fade_done (fade_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] out;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   total_cnt = 0;
  int   bad_cnt   = 0;

  // reference model state
  logic [1:0] m_q;
  int         m_pwm;
  int         m_presc;
  int         m_duty[2];
  logic [1:0] m_out;
  logic       m_done;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic step(input logic r, input logic e, input logic [1:0] li);
    exp_t       ex;
    logic [1:0] nout;
    logic       ndone;
    int         nduty[2];
    int         tgt;
    logic       tick;
    logic       on;
    @(negedge clk);
    rst = r; en = e; led_in = li;
    if (r) begin
      m_q = 2'b00; m_pwm = 0; m_presc = 0;
      m_duty[0] = 0; m_duty[1] = 0;
      m_out = 2'b00; m_done = 1'b1;
    end else begin
      tick  = (m_presc == 3);
      ndone = 1'b1;
      for (int i = 0; i < 2; i++) begin
        tgt = m_q[i] ? 15 : 0;
        if (m_duty[i] != tgt) ndone = 1'b0;
        on = (m_duty[i] == 15) || (m_pwm < m_duty[i]);
        nout[i] = e ? on : m_q[i];
        nduty[i] = m_duty[i];
        if (!e) nduty[i] = tgt;
        else if (tick && m_q[i] && m_duty[i] < 15) nduty[i] = m_duty[i] + 1;
        else if (tick && !m_q[i] && m_duty[i] > 0) nduty[i] = m_duty[i] - 1;
      end
      m_duty[0] = nduty[0]; m_duty[1] = nduty[1];
      m_out = nout; m_done = ndone;
      m_q = li;
      m_pwm = (m_pwm + 1) % 16;
      m_presc = (m_presc + 1) % 4;
    end
    exp_q.push_back('{out: m_out, done: m_done});
    @(posedge clk);
    #1;
    ex = exp_q.pop_front();
    chk("led_out", {6'd0, led_out}, {6'd0, ex.out});
    chk("fade_done", {7'd0, fade_done}, {7'd0, ex.done});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    rst = 1'b1; en = 1'b1; led_in = 2'b11;

    // 1. reset with led_in=11
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 2'b11);
      chk("rst_out", {6'd0, led_out}, 8'h00);
      chk("rst_done", {7'd0, fade_done}, 8'h01);
    end
    step(1'b0, 1'b1, 2'b01);
    chk("post_rst_out", {6'd0, led_out}, 8'h00);
    chk("post_rst_done", {7'd0, fade_done}, 8'h01);

    // 2. ramp channel 0 up
    n = 0; cnt = 0;
    while (m_duty[0] != 15 && n < 200) begin
      step(1'b0, 1'b1, 2'b01);
      if (!fade_done) cnt++;
      n++;
    end
    chk("ramp_up_bound", {7'd0, (n < 200)}, 8'h01);
    chk("ramp_done_low", {7'd0, (cnt > 0)}, 8'h01);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 2'b01);
      cnt += led_out[0];
      if (led_out[1]) cnt += 100;
    end
    chk("full_on_cnt", cnt[7:0], 8'd16);
    chk("full_done", {7'd0, fade_done}, 8'h01);

    // 3. ramp down, no wrap
    n = 0;
    while (m_duty[0] != 0 && n < 200) begin
      step(1'b0, 1'b1, 2'b00);
      n++;
    end
    chk("ramp_dn_bound", {7'd0, (n < 200)}, 8'h01);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 2'b00);
      cnt += led_out[0];
    end
    chk("off_cnt", cnt[7:0], 8'd0);
    chk("off_done", {7'd0, fade_done}, 8'h01);

    // 4. bypass, then return to fade without a glitch
    step(1'b0, 1'b0, 2'b10);
    step(1'b0, 1'b0, 2'b10);
    chk("bypass_out", {6'd0, led_out}, 8'h02);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 2'b10);
      if (!led_out[1]) cnt++;
    end
    chk("no_glitch", cnt[7:0], 8'd0);

    // 5. reset mid-ramp at duty[0]=7
    n = 0;
    while (m_duty[0] != 7 && n < 200) begin
      step(1'b0, 1'b1, 2'b01);
      n++;
    end
    chk("mid_bound", {7'd0, (n < 200)}, 8'h01);
    step(1'b1, 1'b1, 2'b01);
    chk("mid_rst_out", {6'd0, led_out}, 8'h00);
    chk("mid_rst_done", {7'd0, fade_done}, 8'h01);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 2'b01);

    // 6. one-cycle pulses: between ticks, then aligned to a tick
    n = 0;
    while ((m_duty[0] != 0 || m_duty[1] != 0 || m_q != 2'b00) && n < 200) begin
      step(1'b0, 1'b1, 2'b00);
      n++;
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'b00);
    chk("settle_bound", {7'd0, (n < 200)}, 8'h01);
    while (m_presc != 0) step(1'b0, 1'b1, 2'b00);
    step(1'b0, 1'b1, 2'b01);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 2'b00);
      if (!fade_done) cnt++;
    end
    chk("pulse_off_tick", cnt[7:0], 8'd1);
    while (m_presc != 2) step(1'b0, 1'b1, 2'b00);
    step(1'b0, 1'b1, 2'b01);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 2'b00);
      if (!fade_done) cnt++;
    end
    chk("pulse_on_tick", cnt[7:0], 8'd5);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
